// File: rtl/sd_spi_pkg.sv
// Shared constants for the SD SPI-mode card responder.
// Command indices, R1 bits, tokens, OCR value and FSM state encoding.
package sd_spi_pkg;

    localparam logic [5:0] CMD_GO_IDLE      = 6'd0;
    localparam logic [5:0] CMD_SEND_IF_COND = 6'd8;
    localparam logic [5:0] CMD_STOP         = 6'd12;
    localparam logic [5:0] CMD_SET_BLOCKLEN = 6'd16;
    localparam logic [5:0] CMD_READ_SINGLE  = 6'd17;
    localparam logic [5:0] CMD_READ_MULTI   = 6'd18;
    localparam logic [5:0] CMD_SD_SEND_OP   = 6'd41;
    localparam logic [5:0] CMD_APP          = 6'd55;
    localparam logic [5:0] CMD_READ_OCR     = 6'd58;

    localparam logic [7:0] R1_READY   = 8'h00;
    localparam logic [7:0] R1_IDLE    = 8'h01;
    localparam logic [7:0] R1_ILLEGAL = 8'h04;

    localparam logic [7:0]  START_TOKEN = 8'hFE;
    localparam logic [31:0] OCR_SDHC    = 32'hC0FF8000;
    localparam logic [23:0] CMD8_PREFIX = 24'h000001;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_NCR,
        ST_TX_R1,
        ST_TX_TAIL,
        ST_WAIT_NAC,
        ST_TX_TOKEN,
        ST_TX_DATA,
        ST_TX_CRC
    } state_t;

endpackage

// File: rtl/sd_crc16.sv
// Bit-serial CRC16-CCITT (poly 0x1021, init 0), MSB first.
// Ports: clk, rst (sync, high), clr (restart), en (take din), din, crc.
module sd_crc16 (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        en,
    input  logic        din,
    output logic [15:0] crc
);

    logic fb;
    assign fb = crc[15] ^ din;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            crc <= 16'h0000;
        end else if (en) begin
            crc <= {crc[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
        end
    end

endmodule

// File: rtl/sd_spi_responder.sv
// SD card (SPI mode, SDHC) responder for closed-loop host self-test.
// Ports: clk/rst, sclk/cs/mosi from host, miso back; card_ready,
// cmd_valid, cmd_index, blocks_sent and sticky illegal_cmd status.
module sd_spi_responder
    import sd_spi_pkg::*;
#(
    parameter int NCR_BYTES   = 1,
    parameter int NAC_BYTES   = 4,
    parameter int IDLE_POLLS  = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sclk,
    input  logic        cs,
    input  logic        mosi,
    output logic        miso,
    output logic        card_ready,
    output logic        cmd_valid,
    output logic [5:0]  cmd_index,
    output logic [31:0] blocks_sent,
    output logic        illegal_cmd
);

    // SYNC_STAGES must be at least 2
    logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
    logic sclk_s, cs_s, mosi_s, sclk_d;
    logic rise, fall, load;

    logic [47:0] rx_sh, rx_n;
    logic [2:0]  bit_cnt, fcnt;
    logic        byte_end, frame_done;
    logic [5:0]  idx;
    logic [31:0] arg;
    logic        busy, accept, unused_bits;

    state_t      state, state_n;
    logic [8:0]  cnt;
    logic        cnt_clr, cnt_inc, cnt_stop;
    logic [7:0]  tx_byte, tx_sh, r1;
    logic [31:0] tail, addr;
    logic        tail_en, tail_shift, rd, multi, in_data;
    logic        crc_clr, crc_en, blk_done, app_cmd;
    logic [7:0]  polls;
    logic [15:0] crc;

    logic [7:0]  r1_n;
    logic [31:0] tail_n;
    logic        tail_en_n, rd_n, multi_n, ill_n;
    logic        ready_set, ready_clr, poll_inc;

    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign cs_s   = cs_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    // sclk edges only count while selected
    assign rise = sclk_s & ~sclk_d & ~cs_s;
    assign fall = ~sclk_s & sclk_d & ~cs_s;
    // falling edge after the 8th rising edge starts a new miso byte
    assign load = fall & (bit_cnt == 3'd0);

    assign rx_n       = {rx_sh[46:0], mosi_s};
    assign byte_end   = rise & (bit_cnt == 3'd7);
    assign frame_done = byte_end & (fcnt == 3'd5);
    assign idx        = rx_n[45:40];
    assign arg        = rx_n[39:8];
    assign busy       = (state == ST_TX_DATA) || (state == ST_TX_CRC);
    assign accept     = frame_done & (~busy | (idx == CMD_STOP));
    assign unused_bits = rx_sh[47];

    assign crc_en = (load & (state == ST_TX_DATA))
                  | (fall & ~load & in_data);

    sd_crc16 u_crc (
        .clk (clk),
        .rst (rst),
        .clr (crc_clr),
        .en  (crc_en),
        .din (load ? tx_byte[7] : tx_sh[7]),
        .crc (crc)
    );

    // Command decode: response and side effects for the frame in rx_n
    always_comb begin
        r1_n      = {7'b0, ~card_ready};
        tail_n    = 32'h0;
        tail_en_n = 1'b0;
        rd_n      = 1'b0;
        multi_n   = 1'b0;
        ill_n     = 1'b0;
        ready_set = 1'b0;
        ready_clr = 1'b0;
        poll_inc  = 1'b0;
        unique case (idx)
            CMD_GO_IDLE: begin
                r1_n      = R1_IDLE;
                ready_clr = 1'b1;
            end
            CMD_SEND_IF_COND: begin
                tail_en_n = 1'b1;
                tail_n    = {CMD8_PREFIX, arg[7:0]};
            end
            CMD_SD_SEND_OP: begin
                if (!app_cmd) begin
                    ill_n = 1'b1;
                end else if (polls < 8'(IDLE_POLLS)) begin
                    r1_n     = R1_IDLE;
                    poll_inc = 1'b1;
                end else begin
                    r1_n      = R1_READY;
                    ready_set = 1'b1;
                end
            end
            CMD_READ_OCR: begin
                tail_en_n = 1'b1;
                tail_n    = OCR_SDHC;
            end
            CMD_READ_SINGLE, CMD_READ_MULTI: begin
                if (card_ready) begin
                    r1_n    = R1_READY;
                    rd_n    = 1'b1;
                    multi_n = (idx == CMD_READ_MULTI);
                end else begin
                    ill_n = 1'b1;
                end
            end
            CMD_STOP:         r1_n = R1_READY;
            CMD_APP:          ;
            CMD_SET_BLOCKLEN: ;
            default:          ill_n = 1'b1;
        endcase
        if (ill_n) r1_n = R1_ILLEGAL | {7'b0, ~card_ready};
    end

    // Next state and byte to shift out at each byte boundary
    always_comb begin
        state_n    = state;
        tx_byte    = 8'hFF;
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;
        cnt_stop   = 1'b0;
        crc_clr    = 1'b0;
        blk_done   = 1'b0;
        tail_shift = 1'b0;
        if (load) begin
            case (state)
                ST_IDLE: ;
                ST_WAIT_NCR: begin
                    cnt_inc = 1'b1;
                    if (cnt == 9'(NCR_BYTES - 1)) begin
                        state_n = ST_TX_R1;
                        cnt_clr = 1'b1;
                    end
                end
                ST_TX_R1: begin
                    tx_byte = r1;
                    cnt_clr = 1'b1;
                    if (tail_en)  state_n = ST_TX_TAIL;
                    else if (rd)  state_n = ST_WAIT_NAC;
                    else          state_n = ST_IDLE;
                end
                ST_TX_TAIL: begin
                    tx_byte    = tail[31:24];
                    tail_shift = 1'b1;
                    cnt_inc    = 1'b1;
                    if (cnt == 9'd3) begin
                        state_n = ST_IDLE;
                        cnt_clr = 1'b1;
                    end
                end
                ST_WAIT_NAC: begin
                    cnt_inc = 1'b1;
                    if (cnt == 9'(NAC_BYTES - 1)) begin
                        state_n = ST_TX_TOKEN;
                        cnt_clr = 1'b1;
                    end
                end
                ST_TX_TOKEN: begin
                    tx_byte = START_TOKEN;
                    crc_clr = 1'b1;
                    cnt_clr = 1'b1;
                    state_n = ST_TX_DATA;
                end
                ST_TX_DATA: begin
                    tx_byte = addr[7:0] + cnt[7:0];
                    cnt_inc = 1'b1;
                    if (cnt == 9'd511) begin
                        state_n = ST_TX_CRC;
                        cnt_clr = 1'b1;
                    end
                end
                ST_TX_CRC: begin
                    tx_byte = cnt[0] ? crc[7:0] : crc[15:8];
                    cnt_inc = 1'b1;
                    if (cnt[0]) begin
                        blk_done = 1'b1;
                        cnt_clr  = 1'b1;
                        state_n  = multi ? ST_WAIT_NAC : ST_IDLE;
                    end
                end
            endcase
        end
        if (accept) begin
            state_n = ST_WAIT_NCR;
            // a stop inside a block gets exactly one stuff byte
            cnt_stop = busy;
            cnt_clr  = 1'b1;
        end
        if (cs_s) state_n = ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync   <= '0;
            cs_sync     <= '1;
            mosi_sync   <= '1;
            sclk_d      <= 1'b0;
            rx_sh       <= '0;
            bit_cnt     <= 3'd0;
            fcnt        <= 3'd0;
            cmd_valid   <= 1'b0;
            cmd_index   <= 6'd0;
            illegal_cmd <= 1'b0;
            card_ready  <= 1'b0;
            polls       <= 8'd0;
            app_cmd     <= 1'b0;
            r1          <= 8'hFF;
            tail        <= 32'h0;
            tail_en     <= 1'b0;
            rd          <= 1'b0;
            multi       <= 1'b0;
            addr        <= 32'h0;
            blocks_sent <= 32'h0;
            cnt         <= 9'd0;
            miso        <= 1'b1;
            tx_sh       <= 8'hFF;
            in_data     <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            sclk_d    <= sclk_s;

            if (cs_s) begin
                bit_cnt <= 3'd0;
                fcnt    <= 3'd0;
            end else if (rise) begin
                rx_sh   <= rx_n;
                bit_cnt <= bit_cnt + 3'd1;
                if (byte_end) begin
                    if (fcnt == 3'd0)
                        fcnt <= (rx_n[7:6] == 2'b01) ? 3'd1 : 3'd0;
                    else if (fcnt == 3'd5)
                        fcnt <= 3'd0;
                    else
                        fcnt <= fcnt + 3'd1;
                end
            end

            cmd_valid <= frame_done;
            if (frame_done) cmd_index <= idx;

            if (accept) begin
                r1      <= r1_n;
                tail    <= tail_n;
                tail_en <= tail_en_n;
                rd      <= rd_n;
                multi   <= multi_n;
                app_cmd <= (idx == CMD_APP);
                if (ill_n)    illegal_cmd <= 1'b1;
                if (rd_n)     addr <= arg;
                if (poll_inc) polls <= polls + 8'd1;
                if (ready_set) card_ready <= 1'b1;
                if (ready_clr) begin
                    card_ready <= 1'b0;
                    polls      <= 8'd0;
                end
            end else if (tail_shift) begin
                tail <= {tail[23:0], 8'h00};
            end

            if (blk_done) begin
                blocks_sent <= blocks_sent + 32'd1;
                if (multi) addr <= addr + 32'd1;
            end

            if (cnt_stop)     cnt <= 9'(NCR_BYTES - 1);
            else if (cnt_clr) cnt <= 9'd0;
            else if (cnt_inc) cnt <= cnt + 9'd1;

            if (cs_s) begin
                miso    <= 1'b1;
                tx_sh   <= 8'hFF;
                in_data <= 1'b0;
            end else if (load) begin
                miso    <= tx_byte[7];
                tx_sh   <= {tx_byte[6:0], 1'b1};
                in_data <= (state == ST_TX_DATA);
            end else if (fall) begin
                miso  <= tx_sh[7];
                tx_sh <= {tx_sh[6:0], 1'b1};
            end
        end
    end

endmodule
